// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the SPI ADC sampler
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX      = 3'd1,
        SAMPLE  = 3'd2,
        NULLB   = 3'd3,
        RX      = 3'd4,
        CS_HOLD = 3'd5
    } adc_state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam logic START_BIT   = 1'b1;

    // Bit periods with cs low: start + SGL + channel bits + sample + null + data.
    function automatic int frame_bits(input int data_w, input int cmd_ch_w);
        return 4 + cmd_ch_w + data_w;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - SCLK divider with rise/fall/bit-done strobes, idles low while disabled
module adc_sclk_gen #(
    parameter int SCLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o,
    output logic bit_done_o
);
    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          last;

    assign last       = (cnt_q == CW'(SCLK_DIV - 1));
    assign rise_o     = en_i && last && !sclk_q;
    assign fall_o     = en_i && last && sclk_q;
    assign bit_done_o = fall_o;
    assign sclk_o     = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (last) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - MCP300x-class SPI ADC sampler with single-shot and round-robin scan
// Optional overrun counter output enabled by ADC_OVERRUN_CNT_EN.
module adc_spi_sampler
    import adc_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int N_CH        = 8,
    parameter int CMD_CH_W    = 3,
    parameter int SCLK_DIV    = 4,
    parameter int CS_HIGH_CYC = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                mode_i,
    input  logic                start_i,
    input  logic [CMD_CH_W-1:0] channel_i,
    input  logic                diff_i,
    output logic                cs_o,
    output logic                sclk_o,
    output logic                din_o,
    input  logic                dout_i,
    output logic [DATA_W-1:0]   data_o,
    output logic [CMD_CH_W-1:0] data_ch_o,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic                busy_o,
    output logic                overrun_o
`ifdef ADC_OVERRUN_CNT_EN
    ,
    output logic [15:0]         overrun_cnt_o
`endif
);
    localparam int CMD_W      = 2 + CMD_CH_W;
    localparam int FRAME_BITS = frame_bits(DATA_W, CMD_CH_W);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int HOLD_W     = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
    localparam logic [CMD_CH_W-1:0] LAST_CH = CMD_CH_W'(N_CH - 1);

    adc_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CMD_W-1:0]    tx_sr_q, tx_sr_d, cmd;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d, data_q, data_d;
    logic [CMD_CH_W-1:0] frame_ch_q, frame_ch_d, ptr_q, ptr_d, data_ch_q, data_ch_d;
    logic                frame_scan_q, frame_scan_d;
    logic                din_q, din_d, cs_q, cs_d;
    logic                valid_q, valid_d, overrun_q, overrun_d;
    logic                in_frame, go, hold_last, launch, done;
    logic                sclk_rise, sclk_fall, bit_done;

    assign in_frame  = (state_q == TX) || (state_q == SAMPLE) || (state_q == NULLB) || (state_q == RX);
    assign go        = enable_i && ((mode_i == MODE_SCAN) || start_i);
    assign hold_last = (state_q == CS_HOLD) && (hold_cnt_q == HOLD_W'(CS_HIGH_CYC - 1));
    assign launch    = go && ((state_q == IDLE) || hold_last);

    adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (in_frame),
        .sclk_o     (sclk_o),
        .rise_o     (sclk_rise),
        .fall_o     (sclk_fall),
        .bit_done_o (bit_done)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        frame_ch_d   = frame_ch_q;
        frame_scan_d = frame_scan_q;
        ptr_d        = ptr_q;
        din_d        = din_q;
        cs_d         = cs_q;
        data_d       = data_q;
        data_ch_d    = data_ch_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
        done         = 1'b0;
        cmd          = '0;

        case (state_q)
            IDLE: ;
            TX: begin
                if (sclk_fall) begin
                    din_d   = tx_sr_q[CMD_W-1];
                    tx_sr_d = tx_sr_q << 1;
                end
                if (bit_done) begin
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        state_d   = SAMPLE;
                        bit_cnt_d = '0;
                        din_d     = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            SAMPLE: if (bit_done) state_d = NULLB;
            NULLB:  if (bit_done) state_d = RX;
            RX: begin
                if (sclk_rise) rx_sr_d = {rx_sr_q[DATA_W-2:0], dout_i};
                if (bit_done) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d    = CS_HOLD;
                        cs_d       = 1'b1;
                        hold_cnt_d = '0;
                        done       = 1'b1;
                        if (frame_scan_q) ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                if (hold_last) state_d = IDLE;
                else           hold_cnt_d = hold_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Channel/diff/mode are captured once per frame so mid-frame input changes wait a frame.
        if (launch) begin
            frame_ch_d   = (mode_i == MODE_SCAN) ? ptr_q : channel_i;
            frame_scan_d = (mode_i == MODE_SCAN);
            cmd          = {START_BIT, ~diff_i, frame_ch_d};
            din_d        = cmd[CMD_W-1];
            tx_sr_d      = cmd << 1;
            bit_cnt_d    = '0;
            state_d      = TX;
            cs_d         = 1'b0;
        end

        if (done) begin
            data_d    = rx_sr_q;
            data_ch_d = frame_ch_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !data_ready_i;
        end else if (valid_q && data_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            frame_ch_q   <= '0;
            frame_scan_q <= 1'b0;
            ptr_q        <= '0;
            din_q        <= 1'b0;
            cs_q         <= 1'b1;
            data_q       <= '0;
            data_ch_q    <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            frame_ch_q   <= frame_ch_d;
            frame_scan_q <= frame_scan_d;
            ptr_q        <= ptr_d;
            din_q        <= din_d;
            cs_q         <= cs_d;
            data_q       <= data_d;
            data_ch_q    <= data_ch_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cs_o         = cs_q;
    assign din_o        = din_q;
    assign data_o       = data_q;
    assign data_ch_o    = data_ch_q;
    assign data_valid_o = valid_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != IDLE);

`ifdef ADC_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q;
    logic        enable_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_cnt_q     <= '0;
            enable_prev_q <= 1'b0;
        end else begin
            enable_prev_q <= enable_i;
            if (enable_prev_q && !enable_i)           ovr_cnt_q <= '0;
            else if (overrun_q && ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - self-checking bench for adc_spi_sampler with a behavioural ADC model
module tb_adc_spi_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0, mode = 1'b0, start = 1'b0, diff = 1'b0, ready = 1'b0;
    logic [2:0] channel = '0;
    logic       cs_o, sclk_o, din_o, busy_o, overrun_o, data_valid_o;
    logic [9:0] data_o;
    logic [2:0] data_ch_o;
    logic       adc_dout = 1'b0;
`ifdef ADC_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
`endif

    int passed = 0;
    int total  = 0;

    // ADC conversion results indexed by {SGL, channel}
    logic [9:0] tbl [16];

    always #5 clk = ~clk;

    adc_spi_sampler dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .mode_i       (mode),
        .start_i      (start),
        .channel_i    (channel),
        .diff_i       (diff),
        .cs_o         (cs_o),
        .sclk_o       (sclk_o),
        .din_o        (din_o),
        .dout_i       (adc_dout),
        .data_o       (data_o),
        .data_ch_o    (data_ch_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (ready),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
`ifdef ADC_OVERRUN_CNT_EN
        ,
        .overrun_cnt_o(overrun_cnt)
`endif
    );

    // ADC device model and bus monitor; sees pre-edge values at each clock edge
    int rises = 0, low_cnt = 0, high_cnt = 0, frames = 0;
    int last_low = 0, last_rises = 0, last_gap = 0;
    int sclk_bad = 0, din_bad = 0, ovr_total = 0;
    logic [4:0] cmd = '0, last_cmd = '0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0;
    logic [9:0] val;

    always @(posedge clk) begin
        if (rst) begin
            rises = 0;
            adc_dout <= 1'b0;
        end else begin
            if (cs_o && sclk_o) sclk_bad++;
            if (din_o !== prev_din && sclk_o) din_bad++;
            if (!cs_o && prev_cs) begin
                last_gap = high_cnt;
                rises = 0; cmd = '0; low_cnt = 0;
            end
            if (cs_o && !prev_cs) begin
                frames++;
                last_low = low_cnt; last_rises = rises; last_cmd = cmd; high_cnt = 0;
            end
            if (cs_o) high_cnt++; else low_cnt++;
            if (sclk_o && !prev_sclk && !cs_o) begin
                if (rises < 5) cmd = {cmd[3:0], din_o};
                rises++;
            end
            if (overrun_o) ovr_total++;
            val = tbl[cmd[3:0]];
            if (!cs_o && rises >= 7 && rises < 17) adc_dout <= val[16 - rises];
            else adc_dout <= 1'b0;
        end
        prev_cs = cs_o; prev_sclk = sclk_o; prev_din = din_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (data_valid_o !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check(tag, data_valid_o, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        check(tag, busy_o, 0);
    endtask

    task automatic single_shot(input logic [2:0] ch, input logic d);
        wait_idle("idle_before_start");
        @(negedge clk);
        mode = 1'b0; enable = 1'b1; channel = ch; diff = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        logic [2:0] ch;
        logic       d;
        int         n, f0, o0;

        for (int i = 0; i < 16; i++) tbl[i] = 10'($urandom);
        tbl[4'b1011] = 10'h2A5;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cs", cs_o, 1);
        check("rst_sclk", sclk_o, 0);
        check("rst_din", din_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ch", data_ch_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst = 1'b0;

        // single-shot, channel 3 single-ended
        single_shot(3'd3, 1'b0);
        check("ss_busy", busy_o, 1);
        wait_valid("ss_valid");
        check("ss_data", data_o, 10'h2A5);
        check("ss_ch", data_ch_o, 3);
        repeat (20) @(negedge clk);
        check("ss_hold_valid", data_valid_o, 1);
        check("ss_hold_data", data_o, 10'h2A5);
        check("ss_cmd", last_cmd, 5'b11011);
        check("ss_rises", last_rises, 17);
        check("ss_cs_low", last_low, 136);
        accept();
        check("ss_accepted", data_valid_o, 0);

        // random single-shots
        for (int i = 0; i < 3; i++) begin
            ch = 3'($urandom_range(0, 7));
            d  = 1'($urandom_range(0, 1));
            single_shot(ch, d);
            wait_valid("rs_valid");
            check("rs_data", data_o, tbl[{~d, ch}]);
            check("rs_ch", data_ch_o, ch);
            @(negedge clk);
            check("rs_cmd", last_cmd, {1'b1, ~d, ch});
            accept();
        end

        // continuous scan with consumer always ready; pointer starts at 0 despite single-shots
        wait_idle("scan_idle");
        d = 1'($urandom_range(0, 1));
        o0 = ovr_total;
        ready = 1'b1; diff = d; mode = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_valid("scan_valid");
            check("scan_ch", data_ch_o, i % 8);
            check("scan_data", data_o, tbl[{~d, 3'(i % 8)}]);
            if (i > 0) check("scan_gap", last_gap >= 8, 1);
            @(negedge clk);
        end
        enable = 1'b0;
        wait_idle("scan_stop");
        check("scan_no_ovr", ovr_total - o0, 0);
        ready = 1'b0;

        // scan with consumer stalled: results overwrite, overrun per lost result
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        d = 1'($urandom_range(0, 1));
        f0 = frames; o0 = ovr_total;
        diff = d; mode = 1'b1; enable = 1'b1;
        n = 0;
        while (frames < f0 + 8 && n < 3000) begin @(negedge clk); n++; end
        check("ovr_frames", frames - f0, 8);
        repeat (3) @(negedge clk);
        check("ovr_pulses", ovr_total - o0, 7);
        check("ovr_valid", data_valid_o, 1);
        check("ovr_ch", data_ch_o, 7);
        check("ovr_data", data_o, tbl[{~d, 3'd7}]);
`ifdef ADC_OVERRUN_CNT_EN
        check("ovr_cnt", overrun_cnt, 7);
`endif
        enable = 1'b0;
        wait_idle("ovr_stop");
        check("ovr_no_extra_frame", frames - f0, 8);
`ifdef ADC_OVERRUN_CNT_EN
        check("ovr_cnt_clear", overrun_cnt, 0);
`endif

        // ready asserted exactly on the completion clock of a new result
        o0 = ovr_total;
        ch = 3'($urandom_range(0, 7));
        d  = 1'($urandom_range(0, 1));
        single_shot(ch, d);
        repeat (135) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("sim_cs_high", cs_o, 1);
        check("sim_valid", data_valid_o, 1);
        check("sim_data", data_o, tbl[{~d, ch}]);
        check("sim_ch", data_ch_o, ch);
        check("sim_ovr", overrun_o, 0);
        @(negedge clk);
        check("sim_no_ovr", ovr_total - o0, 0);
        accept();

        // reset in the middle of RX bit 5 with a pending result
        single_shot(3'($urandom_range(0, 7)), 1'b0);
        wait_valid("mr_first");
        single_shot(3'($urandom_range(0, 7)), 1'b1);
        n = 0;
        while (!(rises == 13 && sclk_o === 1'b1) && n < 2000) begin @(negedge clk); n++; end
        check("mr_reach_rx5", rises, 13);
        rst = 1'b1;
        #1;
        check("mr_cs", cs_o, 1);
        check("mr_sclk", sclk_o, 0);
        check("mr_valid", data_valid_o, 0);
        check("mr_busy", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        ch = 3'($urandom_range(0, 7));
        d  = 1'($urandom_range(0, 1));
        single_shot(ch, d);
        wait_valid("mr_valid_after");
        check("mr_data", data_o, tbl[{~d, ch}]);
        check("mr_ch", data_ch_o, ch);
        @(negedge clk);
        check("mr_cmd", last_cmd, {1'b1, ~d, ch});
        check("mr_rises", last_rises, 17);
        accept();

        // enable dropped at frame bit 3 of a scan
        wait_idle("en_idle");
        d = 1'($urandom_range(0, 1));
        ready = 1'b1; diff = d; mode = 1'b1; enable = 1'b1;
        n = 0;
        while (!(cs_o === 1'b0 && rises == 3) && n < 2000) begin @(negedge clk); n++; end
        check("en_reach_bit3", rises, 3);
        enable = 1'b0;
        wait_valid("en_valid");
        check("en_ch", data_ch_o, 0);
        check("en_data", data_o, tbl[{~d, 3'd0}]);
        repeat (2) @(negedge clk);
        f0 = frames;
        repeat (300) @(negedge clk);
        check("en_no_frame", frames - f0, 0);
        check("en_busy", busy_o, 0);
        check("en_cs", cs_o, 1);

        check("sclk_while_cs_high", sclk_bad, 0);
        check("din_change_sclk_high", din_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
Parametrised successor to the single-channel SPI ADC driver, for MCP300x-class ADCs. Generates SCLK internally from the system clock and drives CS/DIN/DOUT. Supports single-shot and continuous round-robin scan over N_CH channels, in single-ended or differential mode. Results go to the acquisition controller on a valid/ready port tagged with the channel number.

Parameters:
DATA_W, 10, ADC result width in bits; sets the RX phase length.
N_CH, 8, number of channels scanned (1..2**CMD_CH_W).
CMD_CH_W, 3, channel-select bits sent in the command word (D2..D0).
SCLK_DIV, 4, SCLK half-period in clk_i cycles (>=1); one bit period = 2*SCLK_DIV clocks.
CS_HIGH_CYC, 8, minimum clk_i cycles cs_o stays high between frames (>=1).

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  asynchronous, active-high reset.
enable_i  in  1  permits conversions; when low, the block goes idle after the current frame.
mode_i  in  1  0 = single-shot on start_i; 1 = continuous scan.
start_i  in  1  single-shot request (level sampled in IDLE).
channel_i  in  CMD_CH_W  channel for single-shot mode.
diff_i  in  1  1 = differential (SGL/DIFF bit 0); 0 = single-ended.
cs_o  out  1  ADC chip select, active low.
sclk_o  out  1  SPI clock, mode 0 (idles low).
din_o  out  1  command bits to ADC.
dout_i  in  1  serial data from ADC.
data_o  out  DATA_W  result.
data_ch_o  out  CMD_CH_W  channel of data_o.
data_valid_o  out  1  result valid.
data_ready_i  in  1  consumer accepts when valid && ready.
busy_o  out  1  high while a frame is in progress (cs_o low or CS_HOLD).
overrun_o  out  1  one-clk pulse when an unconsumed result is overwritten.

Behaviour:
- Reset (asynchronous): cs_o=1, sclk_o=0, din_o=0, data_o=0, data_ch_o=0, data_valid_o=0, busy_o=0, overrun_o=0, scan pointer=0, state IDLE. Reset mid-frame aborts the frame immediately and returns cs_o high.
- FSM states:
  - IDLE: waits for enable_i && (mode_i || start_i).
    - Latches the channel: channel_i in single mode, scan pointer in scan mode.
    - Latches diff_i, then goes to TX.
  - TX: cs_o=0 on the first cycle; sends 2+CMD_CH_W bits MSB-first: start=1, SGL=~diff, channel bits.
  - SAMPLE: 1 bit period; din_o=0.
  - NULLB: 1 bit period; DOUT is ignored.
  - RX: DATA_W bits, MSB first.
  - CS_HOLD: cs_o=1 for CS_HIGH_CYC clocks.
    - Then goes to TX if enable_i && (mode_i || start_i), else to IDLE.
- SCLK: each bit period is SCLK_DIV clocks low, then SCLK_DIV clocks high. din_o changes only while sclk_o is low (at the start of the bit). dout_i is sampled on the clk_i cycle in which sclk_o rises. sclk_o is 0 whenever cs_o=1.
- Frame length: 4+CMD_CH_W+DATA_W bit periods. Defaults give 17 bits = 136 clocks with cs_o low.
- Result: registered on the clock after the last RX bit. data_valid_o rises at that same edge, and data_ch_o is set with it.
- Handshake: data_o and data_ch_o are held while data_valid_o && !data_ready_i. data_valid_o clears on the clock after valid && ready.
- Overwrite: if a new result completes while data_valid_o is high and not accepted in that cycle:
  - the new result replaces the old one;
  - data_valid_o stays high;
  - overrun_o pulses for 1 clk.
  If data_ready_i is high in that same cycle, the old result is accepted, the new one loads, and no overrun is flagged.
- Scan pointer: increments after each completed scan-mode frame and wraps N_CH-1 -> 0. It is unchanged by single-shot frames. Changing mode_i mid-frame takes effect at the next frame.
- Input sampling: start_i is level-sensitive and is sampled only in IDLE and at the end of CS_HOLD. start_i pulses while busy are ignored.
- enable_i deasserted mid-frame: the frame completes and its result is delivered.

Optional Feature:
- Macro ADC_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt_o [15:0], a saturating count of overrun_o pulses. It resets to 0, clears when enable_i falls, and holds at 16'hFFFF.
- Undefined: the port and counter are absent; overrun_o is unchanged.

Decomposition:
- Package adc_pkg holds:
  - the state enum (IDLE, TX, SAMPLE, NULLB, RX, CS_HOLD);
  - constants MODE_SINGLE=1'b0, MODE_SCAN=1'b1;
  - the START_BIT constant;
  - a function giving frame length from DATA_W and CMD_CH_W.
- Sub-module adc_sclk_gen: divider producing sclk_o plus one-clk rise/fall strobes and a bit-done strobe. It is enabled by the FSM and is held low and reset while disabled.

Test Plan:
- Single-shot, defaults, mode_i=0, channel_i=3, diff_i=0, start_i pulse: DIN bits 1,1,0,1,1; 17 SCLK rises; cs_o low 136 clks; ADC model returns 10'h2A5 -> data_o=10'h2A5, data_ch_o=3, data_valid_o held until data_ready_i.
- Scan with enable_i=1, mode_i=1, data_ready_i=1: data_ch_o sequence 0,1,...,7,0,1; cs_o high >=8 clks between frames; no overrun.
- Scan with data_ready_i=0: the second result overwrites the first, overrun_o pulses once per lost result, data_valid_o stays 1; with ADC_OVERRUN_CNT_EN, count reads 7 after 8 frames.
- Simultaneous ready and completion: data_ready_i=1 exactly on the completion clock -> old result accepted, new one valid, overrun_o=0.
- rst_i asserted mid-RX (bit 5): cs_o=1 and sclk_o=0 in the same cycle, data_valid_o=0; after release, a new start_i gives a clean frame from the start bit.
- enable_i dropped at frame bit 3 in scan mode: the frame completes, the result is delivered, the FSM goes to IDLE, busy_o=0, and no further cs_o assertion occurs.
